// File: rtl/multicycle_cpu16.sv
// 16-bit multicycle CPU with one shared request/acknowledge memory port.
// Each instruction steps through FETCH, DECODE, EXEC, MEM and WB as needed; HALT is absorbing.
module multicycle_cpu16 #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] PC_RESET = '0,
  parameter int                NREGS    = 4
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [ADDR_W-1:0] PC,
  output logic [15:0]       IR,
  output logic [15:0]       WD,
  output logic              wd_valid,
  output logic              halted,
  output logic              illegal
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
    OP_NOR  = 4'h4, OP_SLT = 4'h5, OP_ADDI = 4'h7, OP_LW = 4'h8,
    OP_SW   = 4'h9, OP_BEQ = 4'hA, OP_BNE = 4'hB, OP_HALT = 4'hF
  } op_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_ir, r_a, r_b, r_alu, r_mdr;
  logic [15:0]       r_regs [NREGS];

  logic [3:0]        w_op;
  logic [1:0]        w_rs, w_rt, w_rd, w_wb_idx;
  logic [15:0]       w_imm, w_alu, w_wb_data, w_rs_val, w_rt_val;
  logic [ADDR_W-1:0] w_br_off, w_daddr;
  logic              w_req, w_ack, w_is_rtype, w_illegal_op, w_taken, w_is_mem;

  assign w_op   = r_ir[15:12];
  assign w_rs   = r_ir[11:10];
  assign w_rt   = r_ir[9:8];
  assign w_rd   = r_ir[7:6];
  assign w_imm  = {{8{r_ir[7]}}, r_ir[7:0]};
  assign w_br_off = {{(ADDR_W-9){r_ir[7]}}, r_ir[7:0], 1'b0};
  assign w_daddr  = ADDR_W'(r_alu);

  assign w_is_rtype   = (w_op <= OP_SLT);
  assign w_illegal_op = (w_op == 4'h6) || (w_op >= 4'hC && w_op <= 4'hE);
  assign w_is_mem     = (w_op == OP_LW) || (w_op == OP_SW);
  assign w_taken      = ((w_op == OP_BEQ) && (r_a == r_b)) || ((w_op == OP_BNE) && (r_a != r_b));
  assign w_wb_data    = (w_op == OP_LW) ? r_mdr : r_alu;
  assign w_wb_idx     = w_is_rtype ? w_rd : w_rt;

  assign w_rs_val = (int'(w_rs) < NREGS) ? r_regs[w_rs] : '0;
  assign w_rt_val = (int'(w_rt) < NREGS) ? r_regs[w_rt] : '0;

  // Memory port is a pure function of state so it stays stable across wait cycles.
  assign w_req     = ((r_state == FETCH) || (r_state == MEM)) && !reset;
  assign w_ack     = mem_ack && w_req;
  assign mem_req   = w_req;
  assign mem_we    = (r_state == MEM) && (w_op == OP_SW);
  assign mem_addr  = (r_state == MEM) ? {w_daddr[ADDR_W-1:1], 1'b0} : {r_pc[ADDR_W-1:1], 1'b0};
  assign mem_wdata = (r_state == MEM) ? r_b : '0;

  assign PC = r_pc;
  assign IR = r_ir;

  always_comb begin
    w_alu = r_a + w_imm;
    case (w_op)
      OP_ADD:  w_alu = r_a + r_b;
      OP_SUB:  w_alu = r_a - r_b;
      OP_AND:  w_alu = r_a & r_b;
      OP_OR:   w_alu = r_a | r_b;
      OP_NOR:  w_alu = ~(r_a | r_b);
      OP_SLT:  w_alu = {15'd0, $signed(r_a) < $signed(r_b)};
      default: ;
    endcase
  end

  // NOTE: every signal written here gets a default first so no path can infer a latch.
  always_comb begin
    w_next   = r_state;
    WD       = '0;
    wd_valid = 1'b0;
    halted   = 1'b0;
    illegal  = 1'b0;
    case (r_state)
      FETCH:  if (w_ack) w_next = DECODE;
      DECODE: begin
        if (w_op == OP_HALT) w_next = HALT;
        else if (w_illegal_op) begin
          illegal = 1'b1;
          w_next  = FETCH;
        end else w_next = EXEC;
      end
      EXEC: begin
        if (w_is_mem) w_next = MEM;
        else if ((w_op == OP_BEQ) || (w_op == OP_BNE)) w_next = FETCH;
        else w_next = WB;
      end
      MEM:    if (w_ack) w_next = (w_op == OP_SW) ? FETCH : WB;
      WB: begin
        WD       = w_wb_data;
        wd_valid = 1'b1;
        w_next   = FETCH;
      end
      HALT:   halted = 1'b1;
      default: w_next = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc  <= PC_RESET;
      r_ir  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_alu <= '0;
      r_mdr <= '0;
      // NOTE: the register file is cleared on reset; r0 relies on it and is never written.
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        FETCH: if (w_ack) begin
          r_ir <= mem_rdata;
          r_pc <= r_pc + ADDR_W'(2);
        end
        DECODE: begin
          r_a <= w_rs_val;
          r_b <= w_rt_val;
        end
        EXEC: begin
          r_alu <= w_alu;
          if (w_taken) r_pc <= r_pc + w_br_off;
        end
        MEM: if (w_ack && (w_op == OP_LW)) r_mdr <= mem_rdata;
        WB: if ((w_wb_idx != 2'd0) && (int'(w_wb_idx) < NREGS)) r_regs[w_wb_idx] <= w_wb_data;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_cpu16.sv
// Directed bench for multicycle_cpu16: memory model with programmable wait states,
// write-back scoreboard, and per-scenario checks of timing, reset and halt behaviour.
module tb_multicycle_cpu16;
  localparam logic [15:0] PC0 = 16'h0100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, PC, IR, WD;
  logic        wd_valid, halted, illegal;

  multicycle_cpu16 #(.ADDR_W(16), .PC_RESET(PC0), .NREGS(4)) dut (
    .clock(clock), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .PC(PC), .IR(IR), .WD(WD), .wd_valid(wd_valid), .halted(halted), .illegal(illegal)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Memory model: img is the image written by the stimulus, copied into mem on load.
  logic [15:0] img [256];
  logic [15:0] mem [256];
  logic        load = 1'b0;
  logic        stall_wr = 1'b0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          wr_cnt = 0;
  logic [15:0] pc_w;

  assign mem_ack   = mem_req && (wait_cnt >= ack_delay) && !(stall_wr && mem_we);
  assign mem_rdata = mem[mem_addr[8:1]];

  always @(posedge clock) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (mem_req && mem_ack && mem_we) begin
      mem[mem_addr[8:1]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= reset ? 1 : cyc + 1;

  typedef struct {
    logic [15:0] data;
    bit          care;
  } exp_t;
  exp_t exp_q[$];
  int   wd_cyc_q[$];
  int   ill_cyc_q[$];

  always @(negedge clock) begin
    exp_t e;
    if (reset) check("req_in_reset", mem_req, 1'b0);
    else begin
      if (wd_valid) begin
        wd_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) check("wd_extra_pulse", wd_valid, 1'b0);
        else begin
          e = exp_q.pop_front();
          if (e.care) check("wd_data", WD, e.data);
        end
      end
      if (illegal) ill_cyc_q.push_back(cyc);
    end
  end

  logic        prev_pend = 1'b0;
  logic [33:0] prev_bus = '0;
  always @(negedge clock) begin
    if (!reset && prev_pend)
      check("mem_stable", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, prev_bus[32:0]});
    prev_pend <= !reset && mem_req && !mem_ack;
    prev_bus  <= {mem_req, mem_we, mem_addr, mem_wdata};
  end

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 16'h0000;
    pc_w = PC0;
  endtask

  task automatic emit(input logic [15:0] w);
    img[pc_w[8:1]] = w;
    pc_w = pc_w + 16'd2;
  endtask

  task automatic exp_wd(input logic [15:0] d, input bit care = 1'b1);
    exp_t e;
    e.data = d;
    e.care = care;
    exp_q.push_back(e);
  endtask

  task automatic start(input bit chk);
    wd_cyc_q.delete();
    ill_cyc_q.delete();
    reset = 1'b1;
    load  = 1'b1;
    @(posedge clock);
    #1 load = 1'b0;
    if (chk) begin
      @(negedge clock);
      check("rst_pc", PC, PC0);
      check("rst_ir_wd", {IR, WD}, 32'h0);
      check("rst_flags", {wd_valid, halted, illegal, mem_req}, 4'b0000);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("first_fetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, PC0});
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(tag, halted, 1'b1);
  endtask

  task automatic check_idle(input string tag);
    int bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (mem_req || !halted) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int wr0;

    // Two loads, signed compare and a not-taken beq; final add yields 7-5.
    clear_img();
    img[0] = 16'd5;
    img[1] = 16'd7;
    emit(16'h8100); emit(16'h8202); emit(16'h56C0); emit(16'hAC02);
    emit(16'h1140); emit(16'hA001); emit(16'h1280); emit(16'h06C0); emit(16'hF000);
    exp_wd(16'd5); exp_wd(16'd7); exp_wd(16'd1); exp_wd(16'hFFFB); exp_wd(16'd2);
    start(1'b1);
    wait_halt("halt_beq", 200);
    check("lw1_cycle", wd_cyc_q[0], 5);
    check("lw2_cycle", wd_cyc_q[1], 10);
    check("add_cycle_beq", wd_cyc_q[4], 28);
    check("halt_pc", PC, PC0 + 16'h12);
    check("sb_empty_beq", exp_q.size(), 0);
    check_idle("halt_idle_beq");

    // Same program with bne: taken, so r2 is negated and the add yields 5-7.
    img[PC0[8:1] + 3] = 16'hBC02;
    exp_wd(16'd5); exp_wd(16'd7); exp_wd(16'd1); exp_wd(16'hFFF9); exp_wd(16'hFFFE);
    start(1'b0);
    wait_halt("halt_bne", 200);
    check("add_cycle_bne", wd_cyc_q[4], 25);
    check("sb_empty_bne", exp_q.size(), 0);

    // Three wait cycles on every access stretch a 4-cycle addi to 7.
    clear_img();
    emit(16'h7109); emit(16'hF000);
    exp_wd(16'd9);
    ack_delay = 3;
    start(1'b0);
    wait_halt("halt_wait", 100);
    check("wait_wb_cycle", wd_cyc_q[0], 7);
    check("sb_empty_wait", exp_q.size(), 0);
    ack_delay = 0;

    // Writes to r0 are discarded; the r1 copy of r0 is stored over a marker.
    clear_img();
    img[2] = 16'hBEEF;
    emit(16'h7005); emit(16'h0040); emit(16'h9104); emit(16'hF000);
    exp_wd(16'd5, 1'b0); exp_wd(16'd0);
    wr0 = wr_cnt;
    start(1'b0);
    wait_halt("halt_r0", 100);
    check("r0_wd_pulses", wd_cyc_q.size(), 2);
    check("r1_stored_zero", mem[2], 16'h0000);
    check("r0_one_write", wr_cnt - wr0, 1);

    // Reset lands while a store waits for its acknowledge.
    clear_img();
    img[3] = 16'h1234;
    emit(16'h7155); emit(16'h9106); emit(16'hF000);
    exp_wd(16'h0055);
    stall_wr = 1'b1;
    start(1'b0);
    n = 0;
    while (!(mem_req && mem_we) && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("sw_pending_seen", mem_req && mem_we, 1'b1);
    check("sw_bus", {mem_addr, mem_wdata}, {16'h0006, 16'h0055});
    wr0 = wr_cnt;
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("req_dropped_on_reset", mem_req, 1'b0);
    @(negedge clock);
    check("pc_after_reset", PC, PC0);
    check("no_write_on_reset", {mem[3], 16'(wr_cnt - wr0)}, {16'h1234, 16'h0000});
    stall_wr = 1'b0;
    exp_wd(16'h0055);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("refetch_after_reset", {mem_req, mem_addr}, {1'b1, PC0});
    wait_halt("halt_reset", 100);
    check("store_after_restart", mem[3], 16'h0055);

    // Illegal opcodes pulse once each and fetch continues at the next word.
    clear_img();
    emit(16'h6000); emit(16'hE123); emit(16'h7103); emit(16'hF000);
    exp_wd(16'd3);
    start(1'b0);
    n = 0;
    while (!illegal && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("illegal_seen", illegal, 1'b1);
    @(negedge clock);
    check("fetch_after_illegal", {mem_req, mem_addr}, {1'b1, PC0 + 16'h2});
    wait_halt("halt_illegal", 100);
    check("illegal_count", ill_cyc_q.size(), 2);
    check("illegal_cycles", {ill_cyc_q[0], ill_cyc_q[1]}, {32'd2, 32'd4});
    check("addi_after_illegal", wd_cyc_q[0], 8);
    check_idle("halt_idle_illegal");

    // Logic ops, signed slt both ways, unaligned lw, and a backward bne loop.
    clear_img();
    img[2] = 16'h00AB;
    emit(16'h71FC); emit(16'h7206); emit(16'h26C0); emit(16'h36C0); emit(16'h46C0);
    emit(16'h56C0); emit(16'h59C0); emit(16'h19C0); emit(16'h8BFF);
    emit(16'h7501); emit(16'hB4FE); emit(16'hF000);
    exp_wd(16'hFFFC); exp_wd(16'h0006); exp_wd(16'h0004); exp_wd(16'hFFFE); exp_wd(16'h0001);
    exp_wd(16'h0001); exp_wd(16'h0000); exp_wd(16'h000A); exp_wd(16'h00AB);
    exp_wd(16'hFFFD); exp_wd(16'hFFFE); exp_wd(16'hFFFF); exp_wd(16'h0000);
    start(1'b0);
    wait_halt("halt_alu", 400);
    check("alu_pc", PC, PC0 + 16'h18);
    check("sb_empty_alu", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/multicycle_cpu16.md
MULTICYCLE_CPU16 -- requirements
Module: multicycle_cpu16

Interface
REQ-001 SHALL provide parameter ADDR_W, default 16, width of the byte address and PC.
REQ-002 SHALL provide parameter PC_RESET, default 0, PC value loaded on reset.
REQ-003 SHALL provide parameter NREGS, default 4, number of 16-bit registers; register fields are 2 bits, so values above 4 are unused.
REQ-004 SHALL provide the port clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL provide the port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 SHALL provide mem_req, output, 1 bit: memory request valid.
REQ-007 SHALL provide mem_we, output, 1 bit: 1 for a write, 0 for a read.
REQ-008 SHALL provide mem_addr, output, ADDR_W bits: byte address; bit 0 is always 0.
REQ-009 SHALL provide mem_wdata, output, 16 bits: store data.
REQ-010 SHALL provide mem_ack, input, 1 bit: the request completes in the cycle it is sampled high.
REQ-011 SHALL provide mem_rdata, input, 16 bits: read data, valid in the mem_ack cycle.
REQ-012 SHALL provide PC, output, ADDR_W bits: current instruction address.
REQ-013 SHALL provide IR, output, 16 bits: latched instruction.
REQ-014 SHALL provide WD, output, 16 bits: write-back data.
REQ-015 SHALL provide wd_valid, output, 1 bit: one-cycle pulse when a register is written.
REQ-016 SHALL provide halted, output, 1 bit: the core is stopped.
REQ-017 SHALL provide illegal, output, 1 bit: one-cycle pulse on an undefined opcode.

Function
REQ-018 SHALL decode the instruction fields as op=IR[15:12], rs=IR[11:10], rt=IR[9:8], rd=IR[7:6], imm=IR[7:0] sign-extended to 16 bits.
REQ-019 SHALL implement these opcodes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 nor, 0101 slt (signed), 0111 addi, 1000 lw rt,imm(rs), 1001 sw rt,imm(rs), 1010 beq, 1011 bne, 1111 halt; 0110 and 1100-1110 are illegal.
REQ-020 SHALL use an FSM with states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-021 SHALL run FETCH as follows: mem_req=1, mem_we=0, mem_addr=PC; on mem_ack, IR<=mem_rdata and PC<=PC+2, then go to DECODE.
REQ-022 SHALL run DECODE as follows: read rs and rt into A and B; halt goes to HALT, illegal pulses illegal and goes to FETCH, all other opcodes go to EXEC.
REQ-023 SHALL run EXEC as follows: ALUOut<=result; R-type and addi go to WB; lw and sw go to MEM (address A+sext(imm)).
REQ-024 SHALL resolve branches in EXEC: beq and bne compare A and B; if taken, PC<=PC+(sext(imm)<<1); branches then go to FETCH.
REQ-025 SHALL run MEM as follows: mem_req=1 with mem_addr=ALUOut & ~1; sw drives mem_we=1 and mem_wdata=B, then goes to FETCH on ack; lw latches mem_rdata on ack, then goes to WB.
REQ-026 SHALL run WB as follows: write to rd (R-type) or rt (addi, lw); WD=data and wd_valid=1 for exactly this cycle.
REQ-027 SHALL give zero-wait latencies of R-type/addi 4 cycles, lw 5, sw 4, branch 3, and illegal 2.
REQ-028 SHALL extend every latency by one cycle per cycle that mem_ack is low.
REQ-029 SHALL allow mem_ack in the same cycle as mem_req (combinational ack).
REQ-030 SHALL hold mem_addr, mem_we and mem_wdata stable while mem_req=1 and mem_ack=0.
REQ-031 SHALL keep mem_req=0 in DECODE, EXEC, WB and HALT.
REQ-032 SHALL ignore mem_ack whenever mem_req=0.
REQ-033 SHALL make register 0 read as 0 and discard writes to it; wd_valid still pulses on such a write.
REQ-034 SHALL perform all arithmetic modulo 2^16 with no overflow trap.
REQ-035 SHALL wrap the PC modulo 2^ADDR_W.
REQ-036 SHALL make HALT absorbing: halted=1 and no memory requests; only reset exits HALT.

Reset
REQ-037 SHALL, on a reset sampled high, set state=FETCH, PC=PC_RESET, IR=0, all registers=0, and WD, wd_valid, illegal and halted to 0.
REQ-038 SHALL hold mem_req=0 during every cycle in which reset is high.
REQ-039 SHALL abandon any pending memory request on reset, with no register or PC side effect.
REQ-040 SHALL issue the first fetch in the first cycle after reset deasserts.

Verification
REQ-041 SHALL cover lw at zero wait: mem[0]=5, mem[2]=7, program lw r1,0(r0)=0x8100 then lw r2,2(r0)=0x8202 -> WD=5 with wd_valid at cycle 5, then WD=7 at cycle 10.
REQ-042 SHALL cover the swap/abs program with data 5,7: slt r3,r1,r2 gives WD=1; beq r3,r0,+2 is not taken; the final add gives WD=2, and gives WD=-2 (0xFFFE) when bne is used instead.
REQ-043 SHALL cover wait states: mem_ack delayed 3 cycles on every access -> mem_addr/mem_req stay stable, and an R-type completes in 7 cycles.
REQ-044 SHALL cover writes to r0: addi r0,r0,5 then add r1,r0,r0 -> WD=0 and r1=0.
REQ-045 SHALL cover reset during the MEM wait of sw -> mem_req=0 the next cycle, no memory write completes, and PC=PC_RESET.
REQ-046 SHALL cover halt and illegal opcodes: opcode 0xF000 -> halted=1 and no mem_req for 20 cycles; opcode 0x6000 -> illegal pulses once, then fetch resumes at PC+2.
